// File: rtl/demux_stream_n_pkg.sv
// Shared constants for the 1-to-N stream demultiplexer: default widths,
// datapath channel indices and route classification.
package demux_stream_n_pkg;

    localparam int DEF_DW   = 8;
    localparam int DEF_N_CH = 8;
    localparam int DEF_SW   = 3;
    localparam int DEF_CW   = 8;

    localparam int MIN_N_CH = 2;
    localparam int MAX_N_CH = 16;

    // Channel indices used by the datapath when wiring the default 8-channel build.
    localparam int CH_ALU0 = 0;
    localparam int CH_ALU1 = 1;
    localparam int CH_MUL  = 2;
    localparam int CH_DIV  = 3;
    localparam int CH_LSU  = 4;
    localparam int CH_BRU  = 5;
    localparam int CH_FPU  = 6;
    localparam int CH_CSR  = 7;

    typedef enum logic [1:0] {
        ROUTE_UNICAST = 2'd0,
        ROUTE_BCAST   = 2'd1,
        ROUTE_DROP    = 2'd2
    } route_e;

    // True when a select of width sw can address every one of n channels.
    function automatic bit sel_covers(input int sw, input int n);
        return (2 ** sw) >= n;
    endfunction

endpackage

// File: rtl/demux_stream_n_if.sv
// Stream bundle between the distribution logic (master) and the demux (slave):
// one valid/ready input port and N_CH valid/ready output channels.
interface demux_stream_n_if
    import demux_stream_n_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int N_CH = DEF_N_CH,
    parameter int SW   = DEF_SW
);
    logic               in_valid;
    logic               in_ready;
    logic [DW-1:0]      in_data;
    logic [SW-1:0]      in_sel;
    logic               in_bcast;
    logic [N_CH-1:0]    out_valid;
    logic [N_CH-1:0]    out_ready;
    logic [N_CH*DW-1:0] out_data;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/demux_slot.sv
// One-entry output buffer for a single demux channel: a valid bit plus a data
// register, loadable and drainable in the same cycle.
module demux_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] d,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          free
);

    // A full slot being drained this cycle can accept a replacement word.
    assign free = !valid || ready;

    // NOTE: the data register is reset along with the valid bit because the
    // downstream ports expect out_data to read zero straight after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream_n.sv
// Registered 1-to-N stream demultiplexer with per-channel one-entry buffers,
// all-or-nothing broadcast and sinking of out-of-range selects.
module demux_stream_n
    import demux_stream_n_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int N_CH = DEF_N_CH,
    parameter int SW   = DEF_SW,
    parameter int CW   = DEF_CW
) (
    input  logic            clk,
    input  logic            rst,
    demux_stream_n_if.slave bus,
    output logic            err_drop,
    output logic [CW-1:0]   drop_cnt
);

    if (N_CH < MIN_N_CH || N_CH > MAX_N_CH || !sel_covers(SW, N_CH)) begin : g_bad_params
        $error("demux_stream_n: N_CH must be 2..16 and 2**SW must cover N_CH");
    end

    localparam int N_SEL = 2 ** SW;

    route_e            route;
    logic              accept;
    logic              drop;
    logic [N_CH-1:0]   free;
    logic [N_CH-1:0]   load;
    logic [N_SEL-1:0]  free_pad;
    logic [N_CH-1:0]   slot_valid;
    logic [N_CH*DW-1:0] slot_data;

    always_comb begin
        if (bus.in_bcast) begin
            route = ROUTE_BCAST;
        end else if (32'(bus.in_sel) < N_CH) begin
            route = ROUTE_UNICAST;
        end else begin
            route = ROUTE_DROP;
        end
    end

    // Zero-extend so every select value indexes a defined bit.
    always_comb begin
        free_pad            = '0;
        free_pad[N_CH-1:0]  = free;
    end

    // Readiness never looks at in_valid, only at routing and slot state.
    always_comb begin
        case (route)
            ROUTE_BCAST:   bus.in_ready = &free;
            ROUTE_UNICAST: bus.in_ready = free_pad[bus.in_sel];
            default:       bus.in_ready = 1'b1;
        endcase
    end

    assign accept = bus.in_valid && bus.in_ready;
    assign drop   = accept && (route == ROUTE_DROP);

    always_comb begin
        load = '0;
        for (int k = 0; k < N_CH; k++) begin
            load[k] = accept &&
                      ((route == ROUTE_BCAST) ||
                       ((route == ROUTE_UNICAST) && (bus.in_sel == SW'(k))));
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        demux_slot #(.DW(DW)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[k]),
            .d     (bus.in_data),
            .ready (bus.out_ready[k]),
            .valid (slot_valid[k]),
            .data  (slot_data[k*DW +: DW]),
            .free  (free[k])
        );
    end

    assign bus.out_valid = slot_valid;
    assign bus.out_data  = slot_data;

    // Sunk words raise a one-cycle flag and bump a counter that sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_drop <= 1'b0;
            drop_cnt <= '0;
        end else begin
            err_drop <= drop;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule
